// File: rtl/wave_pkg.sv
// Shared types and segment-bound helpers for the arbitrary-wave index sequencer.
// The LUT holds SAMPLES_PER_PERIOD entries split into equal SEG_LEN segments.
package wave_pkg;

    localparam int SAMPLES_PER_PERIOD = 200;
    localparam int SEG_LEN            = 50;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } wig_state_t;

    // Modes 4..7 all select the full sweep, so only mode[2] matters for them.
    function automatic int seg_base(input logic [2:0] mode, input int seg_len);
        if (mode[2]) begin
            return 0;
        end
        return int'(mode[1:0]) * seg_len;
    endfunction

    function automatic int seg_end(input logic [2:0] mode, input int seg_len,
                                   input int samples);
        if (mode[2]) begin
            return samples - 1;
        end
        return seg_base(mode, seg_len) + seg_len - 1;
    endfunction

endpackage

// File: rtl/sample_tick_div.sv
// Programmable rate divider: emits one tick every (div+1) running cycles.
// The divide value is captured on clear and again on each tick.
module sample_tick_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;

    assign o_tick = i_run && (r_cnt == r_div);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_div <= '0;
        end else if (i_clear || o_tick) begin
            r_cnt <= '0;
            r_div <= i_div;
        end else if (i_run) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wave_index_gen.sv
// LUT read-index sequencer: loops one segment or sweeps the whole table at a
// programmable rate, with a one-cycle-delayed strobe matching the LUT read latency.
module wave_index_gen #(
    parameter int SAMPLES_PER_PERIOD = wave_pkg::SAMPLES_PER_PERIOD,
    parameter int SEG_LEN            = wave_pkg::SEG_LEN,
    parameter int IDX_W              = 8,
    parameter int DIV_W              = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic             oneshot,
    input  logic [DIV_W-1:0] div,
    output logic [IDX_W-1:0] index,
    output logic             index_valid,
    output logic             sample_valid,
    output logic             busy,
    output logic             done
);

    import wave_pkg::*;

    wig_state_t       r_state;
    logic [2:0]       r_mode;
    logic             r_oneshot;
    logic [IDX_W-1:0] r_index;
    logic             r_index_valid;
    logic             r_sample_valid;

    logic [IDX_W-1:0] w_base;
    logic [IDX_W-1:0] w_end;
    logic             w_start;
    logic             w_run;
    logic             w_tick;

    // Restart base follows the live mode input (used at start and at a wrap);
    // the end point follows the mode latched for the pass in progress.
    assign w_base  = IDX_W'(seg_base(mode, SEG_LEN));
    assign w_end   = IDX_W'(seg_end(r_mode, SEG_LEN, SAMPLES_PER_PERIOD));
    assign w_start = (r_state == IDLE) && enable;
    assign w_run   = (r_state == RUN) && enable;

    sample_tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_start),
        .i_run   (w_run),
        .i_div   (div),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_mode         <= '0;
            r_oneshot      <= 1'b0;
            r_index        <= '0;
            r_index_valid  <= 1'b0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= r_index_valid;
            if (!enable) begin
                r_state       <= IDLE;
                r_index_valid <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state       <= RUN;
                        r_mode        <= mode;
                        r_oneshot     <= oneshot;
                        r_index       <= w_base;
                        r_index_valid <= 1'b1;
                    end
                    RUN: begin
                        r_index_valid <= 1'b0;
                        if (w_tick) begin
                            if (r_index == w_end) begin
                                if (r_oneshot) begin
                                    r_state <= DONE;
                                end else begin
                                    r_mode        <= mode;
                                    r_oneshot     <= oneshot;
                                    r_index       <= w_base;
                                    r_index_valid <= 1'b1;
                                end
                            end else begin
                                r_index       <= r_index + 1'b1;
                                r_index_valid <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        r_index_valid <= 1'b0;
                    end
                    default: begin
                        r_state       <= IDLE;
                        r_index_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign index        = r_index;
    assign index_valid  = r_index_valid;
    assign sample_valid = r_sample_valid;
    assign busy         = (r_state == RUN);
    assign done         = (r_state == DONE);

endmodule

// File: tb/tb_wave_index_gen.sv
// Directed bench for wave_index_gen: a per-cycle vector table plus hand-written
// sequences for segment loops, one-shot sweeps, rate changes and mid-run reset.
module tb_wave_index_gen;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [2:0]  mode;
    logic        oneshot;
    logic [15:0] div;
    logic [7:0]  index;
    logic        index_valid;
    logic        sample_valid;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    wave_index_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .mode         (mode),
        .oneshot      (oneshot),
        .div          (div),
        .index        (index),
        .index_valid  (index_valid),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [2:0]  mode;
        logic        os;
        logic [15:0] div;
        int          idx;
        int          iv;
        int          sv;
        int          busy;
        int          done;
    } vec_t;

    vec_t tbl [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int e_idx, input int e_iv,
                           input int e_sv, input int e_busy, input int e_done);
        chk({tag, " index"}, int'(index), e_idx);
        chk({tag, " index_valid"}, int'(index_valid), e_iv);
        chk({tag, " sample_valid"}, int'(sample_valid), e_sv);
        chk({tag, " busy"}, int'(busy), e_busy);
        chk({tag, " done"}, int'(done), e_done);
    endtask

    initial begin
        int e_idx;
        int e_iv;
        int e_sv;
        int prev_iv;
        int strobes;

        // rows: en, mode, oneshot, div | index, index_valid, sample_valid, busy, done
        tbl[0]  = '{1'b0, 3'd1, 1'b0, 16'd0, 73, 0, 1, 0, 0};
        tbl[1]  = '{1'b1, 3'd1, 1'b0, 16'd0, 50, 1, 0, 1, 0};
        tbl[2]  = '{1'b1, 3'd1, 1'b0, 16'd0, 51, 1, 1, 1, 0};
        tbl[3]  = '{1'b1, 3'd0, 1'b0, 16'd0, 52, 1, 1, 1, 0};
        tbl[4]  = '{1'b1, 3'd0, 1'b0, 16'd2, 53, 1, 1, 1, 0};
        tbl[5]  = '{1'b1, 3'd0, 1'b0, 16'd2, 53, 0, 1, 1, 0};
        tbl[6]  = '{1'b1, 3'd0, 1'b0, 16'd2, 53, 0, 0, 1, 0};
        tbl[7]  = '{1'b1, 3'd0, 1'b0, 16'd2, 54, 1, 0, 1, 0};
        tbl[8]  = '{1'b0, 3'd0, 1'b0, 16'd2, 54, 0, 1, 0, 0};
        tbl[9]  = '{1'b0, 3'd0, 1'b0, 16'd2, 54, 0, 0, 0, 0};
        tbl[10] = '{1'b1, 3'd0, 1'b1, 16'd0,  0, 1, 0, 1, 0};
        tbl[11] = '{1'b1, 3'd0, 1'b1, 16'd0,  1, 1, 1, 1, 0};

        // Reset held with enable high: nothing may start
        rst_n = 1'b0; enable = 1'b1; mode = 3'd0; oneshot = 1'b0; div = 16'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("rst c%0d", i), 0, 0, 0, 0, 0);
        end
        rst_n = 1'b1;
        step();
        chk_out("rel first", 0, 1, 0, 1, 0);
        step();
        chk_out("rel second", 1, 1, 1, 1, 0);
        enable = 1'b0;
        step();
        chk_out("rel stop", 1, 0, 1, 0, 0);
        step();
        chk_out("rel idle", 1, 0, 0, 0, 0);

        // Segment 1 loop, div=0
        enable = 1'b1; mode = 3'd1; div = 16'd0; oneshot = 1'b0;
        for (int k = 0; k < 54; k++) begin
            step();
            chk_out($sformatf("seg1 k%0d", k), 50 + (k % 50), 1, (k > 0) ? 1 : 0, 1, 0);
        end
        enable = 1'b0;
        step();

        // Full one-shot sweep, div=3
        enable = 1'b1; mode = 3'd4; div = 16'd3; oneshot = 1'b1;
        prev_iv = 0;
        strobes = 0;
        for (int k = 0; k < 804; k++) begin
            step();
            e_iv  = (k < 800 && (k % 4) == 0) ? 1 : 0;
            e_idx = (k < 800) ? (k / 4) : 199;
            chk_out($sformatf("sweep k%0d", k), e_idx, e_iv, prev_iv,
                    (k < 800) ? 1 : 0, (k >= 800) ? 1 : 0);
            if (index_valid) strobes++;
            prev_iv = e_iv;
        end
        chk("sweep strobe count", strobes, 200);
        enable = 1'b0;
        step();
        chk_out("sweep exit", 199, 0, 0, 0, 0);

        // Mode change mid-pass takes effect at the wrap only
        enable = 1'b1; mode = 3'd2; div = 16'd0; oneshot = 1'b0;
        for (int k = 0; k < 56; k++) begin
            step();
            e_idx = (k < 50) ? (100 + k) : (150 + k - 50);
            chk_out($sformatf("mchg k%0d", k), e_idx, 1, (k > 0) ? 1 : 0, 1, 0);
            if (k == 20) mode = 3'd3;
        end
        enable = 1'b0;
        step();

        // Run segment 1 up to index 73, then the vector table
        enable = 1'b1; mode = 3'd1; div = 16'd0; oneshot = 1'b0;
        for (int k = 0; k < 24; k++) begin
            step();
            chk($sformatf("pre k%0d index", k), int'(index), 50 + k);
        end
        for (int r = 0; r < 12; r++) begin
            enable = tbl[r].en; mode = tbl[r].mode; oneshot = tbl[r].os; div = tbl[r].div;
            step();
            chk_out($sformatf("tbl r%0d", r), tbl[r].idx, tbl[r].iv, tbl[r].sv,
                    tbl[r].busy, tbl[r].done);
        end

        // Continue the one-shot segment-0 pass into DONE
        for (int k = 2; k < 50; k++) begin
            step();
            chk_out($sformatf("os0 k%0d", k), k, 1, 1, 1, 0);
        end
        step();
        chk_out("os0 done", 49, 0, 1, 0, 1);
        step();
        chk_out("os0 hold", 49, 0, 0, 0, 1);
        enable = 1'b0;
        step();
        chk_out("os0 exit", 49, 0, 0, 0, 0);

        // Rate change 0 -> 9 -> 0 during a mode-7 full sweep, then wrap at 199
        enable = 1'b1; mode = 3'd7; div = 16'd0; oneshot = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("m7 k%0d index", k), int'(index), k);
        end
        div = 16'd9;
        prev_iv = 1;
        for (int k = 6; k < 220; k++) begin
            step();
            if (k == 6)       begin e_idx = 6; e_iv = 1; end
            else if (k < 16)  begin e_idx = 6; e_iv = 0; end
            else if (k == 16) begin e_idx = 7; e_iv = 1; end
            else if (k < 26)  begin e_idx = 7; e_iv = 0; end
            else              begin e_idx = (8 + k - 26) % 200; e_iv = 1; end
            e_sv = prev_iv;
            chk_out($sformatf("rate k%0d", k), e_idx, e_iv, e_sv, 1, 0);
            prev_iv = e_iv;
            if (k == 16) div = 16'd0;
        end

        // Reset in the middle of a run drops everything including sample_valid
        rst_n = 1'b0;
        step();
        chk_out("midrst", 0, 0, 0, 0, 0);
        rst_n = 1'b1; enable = 1'b0;
        step();
        chk_out("midrst idle", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
